// File: rtl/matmul_c_drain_if.sv
// ----------------------------------------------------------------------------
// matmul_c_drain_if
// Row output stream of the C-matrix drain stage.
//
// Signals
//   out_data   one row of C, lane j = bits [j*DWIDTH +: DWIDTH]
//   out_valid  producer has a row on out_data/out_row/out_last
//   out_ready  consumer can accept a row
//   out_row    row index of the current beat
//   out_last   current beat is the last valid row of this drain
//
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready.
// Once out_valid is high it stays high, and out_data/out_row/out_last stay
// stable, until that transfer happens. out_valid never depends on out_ready.
//
// Modports
//   master  the drain stage (drives the payload, samples out_ready)
//   slave   the consumer (samples the payload, drives out_ready)
// ----------------------------------------------------------------------------
interface matmul_c_drain_if #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4
);
    localparam int RW = (MAT_MUL_SIZE > 1) ? $clog2(MAT_MUL_SIZE) : 1;

    logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [RW-1:0]                  out_row;
    logic                           out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_row,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matmul_c_drain.sv
// ----------------------------------------------------------------------------
// matmul_c_drain
// Reads result matrix C out of the C BRAM external port, one row per BRAM
// word, and emits each valid row on a valid/ready stream. Rows with a clear
// row-mask bit are skipped; lanes with a clear column-mask bit are zeroed.
// A 2-entry buffer absorbs the BRAM's 1-cycle read latency under backpressure.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   start                  one-cycle pulse, begins a drain (IDLE only)
//   clear_done             returns DONE to IDLE
//   address_mat_c          BRAM address of row 0 (sampled at start)
//   address_stride_c       address step between rows (sampled at start)
//   validity_mask_a_rows   bit i: row i valid (sampled at start)
//   validity_mask_b_cols   bit j: lane j valid (sampled at start)
//   bram_addr_c_ext        BRAM read address (holds when no read is issued)
//   bram_rdata_c_ext       BRAM read data, valid the cycle after the address
//   bram_wdata_c_ext       constant 0
//   bram_we_c_ext          constant 0, this block never writes
//   o_out_if               row output stream (master side)
//   busy                   high in RUN
//   done                   high in DONE
//   o_dbg_state            current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ----------------------------------------------------------------------------
module matmul_c_drain #(
    parameter int DWIDTH            = 8,
    parameter int AWIDTH            = 11,
    parameter int MAT_MUL_SIZE      = 4,
    parameter int ADDR_STRIDE_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           clear_done,
    input  logic [AWIDTH-1:0]              address_mat_c,
    input  logic [ADDR_STRIDE_WIDTH-1:0]   address_stride_c,
    input  logic [MAT_MUL_SIZE-1:0]        validity_mask_a_rows,
    input  logic [MAT_MUL_SIZE-1:0]        validity_mask_b_cols,
    output logic [AWIDTH-1:0]              bram_addr_c_ext,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_c_ext,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_c_ext,
    output logic [MAT_MUL_SIZE-1:0]        bram_we_c_ext,
    matmul_c_drain_if.master               o_out_if,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     o_dbg_state
);
    localparam int LW = MAT_MUL_SIZE * DWIDTH;
    localparam int RW = (MAT_MUL_SIZE > 1) ? $clog2(MAT_MUL_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        r_state;
    logic                          r_busy;
    logic                          r_done;
    logic [AWIDTH-1:0]             r_base;
    logic [ADDR_STRIDE_WIDTH-1:0]  r_stride;
    logic [MAT_MUL_SIZE-1:0]       r_row_mask;
    logic [MAT_MUL_SIZE-1:0]       r_col_mask;
    logic [MAT_MUL_SIZE-1:0]       r_pending;      // valid rows not yet read
    logic [AWIDTH-1:0]             r_addr_hold;
    logic                          r_inflight;     // read issued last cycle
    logic [RW-1:0]                 r_inflight_row;
    logic                          r_inflight_last;
    logic [LW-1:0]                 r_fifo_data [2];
    logic [RW-1:0]                 r_fifo_row  [2];
    logic                          r_fifo_last [2];
    logic                          r_wr_ptr;
    logic                          r_rd_ptr;
    logic [1:0]                    r_count;

    logic [RW-1:0]                 w_sel_row;
    logic [MAT_MUL_SIZE-1:0]       w_sel_onehot;
    logic [MAT_MUL_SIZE-1:0]       w_pending_next;
    logic                          w_sel_last;
    logic                          w_issue;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_head_last;
    logic [AWIDTH-1:0]             w_issue_addr;
    logic [AWIDTH-1:0]             w_bram_addr;
    logic [LW-1:0]                 w_push_data;

    // Lowest pending row; the loop runs high to low so the lowest set bit wins.
    always_comb begin
        w_sel_row    = '0;
        w_sel_onehot = '0;
        for (int i = MAT_MUL_SIZE - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel_row    = RW'(i);
                w_sel_onehot = MAT_MUL_SIZE'(1) << i;
            end
        end
    end

    // Rows are read in ascending order, so the selected row is the last valid
    // row exactly when nothing remains pending after it.
    assign w_pending_next = r_pending & ~w_sel_onehot;
    assign w_sel_last     = (w_pending_next == '0);

    // Slot accounting uses the registered count: a pop this cycle frees its
    // slot only next cycle, so the buffer can never overflow.
    assign w_issue = !reset && (r_state == S_RUN) && (r_pending != '0) &&
                     (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2);

    // Row address wraps modulo 2^AWIDTH.
    assign w_issue_addr = r_base + AWIDTH'(r_stride) * AWIDTH'(w_sel_row);
    assign w_bram_addr  = w_issue ? w_issue_addr : r_addr_hold;

    assign w_push      = r_inflight;
    assign w_pop       = (r_count != 2'd0) && o_out_if.out_ready;
    assign w_head_last = r_fifo_last[r_rd_ptr];

    always_comb begin
        w_push_data = '0;
        for (int j = 0; j < MAT_MUL_SIZE; j++) begin
            w_push_data[j*DWIDTH +: DWIDTH] =
                r_col_mask[j] ? bram_rdata_c_ext[j*DWIDTH +: DWIDTH] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_base          <= '0;
            r_stride        <= '0;
            r_row_mask      <= '0;
            r_col_mask      <= '0;
            r_pending       <= '0;
            r_addr_hold     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_row  <= '0;
            r_inflight_last <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                r_fifo_data[k] <= '0;
                r_fifo_row[k]  <= '0;
                r_fifo_last[k] <= 1'b0;
            end
        end else begin
            r_addr_hold <= w_bram_addr;
            r_inflight  <= w_issue;
            if (w_issue) begin
                r_inflight_row  <= w_sel_row;
                r_inflight_last <= w_sel_last;
                r_pending       <= w_pending_next;
            end

            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_row[r_wr_ptr]  <= r_inflight_row;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_base     <= address_mat_c;
                        r_stride   <= address_stride_c;
                        r_row_mask <= validity_mask_a_rows;
                        r_col_mask <= validity_mask_b_cols;
                        r_pending  <= validity_mask_a_rows;
                    end
                end
                S_RUN: begin
                    // An empty row mask has nothing to emit and finishes at once.
                    if ((r_row_mask == '0) || (w_pop && w_head_last)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (clear_done) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bram_addr_c_ext  = w_bram_addr;
    assign bram_wdata_c_ext = '0;
    assign bram_we_c_ext    = '0;

    assign o_out_if.out_valid = (r_count != 2'd0);
    assign o_out_if.out_data  = r_fifo_data[r_rd_ptr];
    assign o_out_if.out_row   = r_fifo_row[r_rd_ptr];
    assign o_out_if.out_last  = r_fifo_last[r_rd_ptr];

    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_matmul_c_drain.sv
// ----------------------------------------------------------------------------
// tb_matmul_c_drain
// Directed bench for matmul_c_drain: a registered-read BRAM model, a passive
// monitor that logs issued addresses and accepted beats, and one task per
// scenario with hand-computed expected beats ({last, row, data}) and addresses.
// ----------------------------------------------------------------------------
module tb_matmul_c_drain;
    localparam int DW = 8;
    localparam int AW = 11;
    localparam int N  = 4;
    localparam int SW = 8;
    localparam int RW = 2;
    localparam int W  = N * DW;
    localparam int BW = W + RW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic          clear_done;
    logic [AW-1:0] address_mat_c;
    logic [SW-1:0] address_stride_c;
    logic [N-1:0]  rmask;
    logic [N-1:0]  cmask;
    logic [AW-1:0] bram_addr;
    logic [W-1:0]  bram_rdata;
    logic [W-1:0]  bram_wdata;
    logic [N-1:0]  bram_we;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    matmul_c_drain_if #(.DWIDTH(DW), .MAT_MUL_SIZE(N)) out_if ();

    matmul_c_drain #(
        .DWIDTH(DW), .AWIDTH(AW), .MAT_MUL_SIZE(N), .ADDR_STRIDE_WIDTH(SW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .clear_done           (clear_done),
        .address_mat_c        (address_mat_c),
        .address_stride_c     (address_stride_c),
        .validity_mask_a_rows (rmask),
        .validity_mask_b_cols (cmask),
        .bram_addr_c_ext      (bram_addr),
        .bram_rdata_c_ext     (bram_rdata),
        .bram_wdata_c_ext     (bram_wdata),
        .bram_we_c_ext        (bram_we),
        .o_out_if             (out_if.master),
        .busy                 (busy),
        .done                 (done),
        .o_dbg_state          (dbg_state)
    );

    // ---------------- BRAM model: 1-cycle registered read ----------------
    logic [W-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) bram_rdata <= mem[bram_addr];

    // ---------------- monitor / scoreboard ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [BW-1:0] got_q[$];
    logic [BW-1:0] exp_q[$];
    logic [AW-1:0] addr_log[$];
    logic [AW-1:0] exp_addr_q[$];
    int            n_issued;
    int            n_accepted;
    int            max_out;
    int            stall_viol;
    logic          prev_stall;
    logic [BW-1:0] prev_beat;
    logic [AW-1:0] prev_addr;
    bit            mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bram_addr !== prev_addr) begin
                addr_log.push_back(bram_addr);
                n_issued++;
                prev_addr = bram_addr;
            end
            if (n_issued - n_accepted > max_out) max_out = n_issued - n_accepted;
            if (prev_stall && (out_if.out_valid !== 1'b1 ||
                {out_if.out_last, out_if.out_row, out_if.out_data} !== prev_beat))
                stall_viol++;
            prev_stall = out_if.out_valid && !out_if.out_ready;
            prev_beat  = {out_if.out_last, out_if.out_row, out_if.out_data};
            if (out_if.out_valid && out_if.out_ready) begin
                got_q.push_back({out_if.out_last, out_if.out_row, out_if.out_data});
                n_accepted++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic mon_clear();
        got_q.delete();
        exp_q.delete();
        addr_log.delete();
        exp_addr_q.delete();
        n_issued   = 0;
        n_accepted = 0;
        max_out    = 0;
        stall_viol = 0;
        prev_stall = 1'b0;
        prev_addr  = bram_addr;
        mon_en     = 1'b1;
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [SW-1:0] stride,
                            input logic [N-1:0] rm, input logic [N-1:0] cm);
        @(posedge clk); #1;
        address_mat_c    = base;
        address_stride_c = stride;
        rmask            = rm;
        cmask            = cm;
        start            = 1'b1;
        @(posedge clk); #1;
        start            = 1'b0;
    endtask

    task automatic pulse_clear_done();
        clear_done = 1'b1;
        @(posedge clk); #1;
        clear_done = 1'b0;
    endtask

    task automatic run_until_done(input int max_cycles, input bit rand_ready,
                                  output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (done === 1'b1) break;
            if (rand_ready) out_if.out_ready = (c < 3) ? 1'b0 : ($urandom_range(0, 1) == 1);
            else            out_if.out_ready = 1'b1;
            @(posedge clk); #1;
        end
        if (done === 1'b1) timed_out = 1'b0;
        out_if.out_ready = 1'b1;
    endtask

    task automatic load_rows_at(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        mem[a0] = 32'h04030201;
        mem[a1] = 32'h08070605;
        mem[a2] = 32'h0C0B0A09;
        mem[a3] = 32'h100F0E0D;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if ({out_if.out_valid, out_if.out_last, busy, done} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags got %b exp 0000", {out_if.out_valid, out_if.out_last, busy, done});
        end
        n_checks++;
        if (bram_addr !== 11'h000 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_addr_state got addr %h state %0d exp addr 000 state 0", bram_addr, dbg_state);
        end
        n_checks++;
        if (out_if.out_data !== 32'h0 || out_if.out_row !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_payload got data %h row %0d exp 0 0", out_if.out_data, out_if.out_row);
        end
        n_checks++;
        if (bram_wdata !== 32'h0 || bram_we !== 4'h0) begin
            n_errors++;
            $display("FAIL bram_write_tie got wdata %h we %h exp 0 0", bram_wdata, bram_we);
        end
    endtask

    task automatic test_full_drain();
        bit to;
        load_rows_at(11'h010, 11'h014, 11'h018, 11'h01C);
        out_if.out_ready = 1'b1;
        mon_clear();
        exp_q      = '{{1'b0, 2'd0, 32'h04030201}, {1'b0, 2'd1, 32'h08070605},
                       {1'b0, 2'd2, 32'h0C0B0A09}, {1'b1, 2'd3, 32'h100F0E0D}};
        exp_addr_q = '{11'h010, 11'h014, 11'h018, 11'h01C};
        do_start(11'h010, 8'd4, 4'hF, 4'hF);
        n_checks++;
        if (busy !== 1'b1 || out_if.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL full_after_start got busy %b valid %b exp 1 0", busy, out_if.out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_if.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL full_latency_early got valid %b exp 0", out_if.out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 32'h04030201) begin
            n_errors++;
            $display("FAIL full_latency_first got valid %b data %h exp 1 04030201", out_if.out_valid, out_if.out_data);
        end
        run_until_done(60, 1'b0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL full_timeout got no done exp done within 60 cycles"); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL full_beat_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL full_beat%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
        n_checks++;
        if (addr_log != exp_addr_q) begin
            n_errors++;
            $display("FAIL full_addrs got %p exp %p", addr_log, exp_addr_q);
        end
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== 2'd2) begin
            n_errors++;
            $display("FAIL full_done_state got busy %b state %0d exp 0 2", busy, dbg_state);
        end
        pulse_clear_done();
        n_checks++;
        if (done !== 1'b0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL full_clear got done %b state %0d exp 0 0", done, dbg_state);
        end
    endtask

    task automatic test_masked();
        bit to;
        out_if.out_ready = 1'b1;
        mon_clear();
        exp_q      = '{{1'b0, 2'd1, 32'h00000605}, {1'b1, 2'd3, 32'h00000E0D}};
        exp_addr_q = '{11'h014, 11'h01C};
        do_start(11'h010, 8'd4, 4'b1010, 4'b0011);
        run_until_done(60, 1'b0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL masked_timeout got no done exp done within 60 cycles"); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL masked_beat_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL masked_beat%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
        n_checks++;
        if (addr_log != exp_addr_q) begin
            n_errors++;
            $display("FAIL masked_addrs got %p exp %p", addr_log, exp_addr_q);
        end
        pulse_clear_done();
    endtask

    task automatic test_backpressure();
        bit to;
        mon_clear();
        exp_q = '{{1'b0, 2'd0, 32'h04030201}, {1'b0, 2'd1, 32'h08070605},
                  {1'b0, 2'd2, 32'h0C0B0A09}, {1'b1, 2'd3, 32'h100F0E0D}};
        do_start(11'h010, 8'd4, 4'hF, 4'hF);
        run_until_done(200, 1'b1, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL bp_timeout got no done exp done within 200 cycles"); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL bp_beat_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL bp_beat%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
        n_checks++;
        if (stall_viol != 0) begin
            n_errors++;
            $display("FAIL bp_stall_stable got %0d changes exp 0", stall_viol);
        end
        n_checks++;
        if (max_out > 2) begin
            n_errors++;
            $display("FAIL bp_outstanding got %0d exp at most 2", max_out);
        end
        pulse_clear_done();
    endtask

    task automatic test_wrap();
        bit to;
        load_rows_at(11'h7FE, 11'h7FF, 11'h000, 11'h001);
        out_if.out_ready = 1'b1;
        mon_clear();
        exp_q      = '{{1'b0, 2'd0, 32'h04030201}, {1'b0, 2'd1, 32'h08070605},
                       {1'b0, 2'd2, 32'h0C0B0A09}, {1'b1, 2'd3, 32'h100F0E0D}};
        exp_addr_q = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        do_start(11'h7FE, 8'd1, 4'hF, 4'hF);
        run_until_done(60, 1'b0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL wrap_timeout got no done exp done within 60 cycles"); end
        n_checks++;
        if (addr_log != exp_addr_q) begin
            n_errors++;
            $display("FAIL wrap_addrs got %p exp %p", addr_log, exp_addr_q);
        end
        n_checks++;
        if (got_q != exp_q) begin
            n_errors++;
            $display("FAIL wrap_beats got %p exp %p", got_q, exp_q);
        end
        pulse_clear_done();
    endtask

    task automatic test_empty_mask();
        mon_clear();
        do_start(11'h010, 8'd4, 4'h0, 4'hF);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL empty_run got busy %b done %b exp 1 0", busy, done);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL empty_done got busy %b done %b exp 0 1", busy, done);
        end
        n_checks++;
        if (n_issued != 0 || n_accepted != 0) begin
            n_errors++;
            $display("FAIL empty_no_traffic got reads %0d beats %0d exp 0 0", n_issued, n_accepted);
        end
        do_start(11'h010, 8'd4, 4'hF, 4'hF);
        @(posedge clk); #1;
        n_checks++;
        if (dbg_state !== 2'd2 || busy !== 1'b0 || n_issued != 0) begin
            n_errors++;
            $display("FAIL start_in_done got state %0d busy %b reads %0d exp 2 0 0", dbg_state, busy, n_issued);
        end
        pulse_clear_done();
        n_checks++;
        if (dbg_state !== 2'd0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL empty_clear got state %0d done %b exp 0 0", dbg_state, done);
        end
    endtask

    task automatic test_reset_mid_drain();
        bit to;
        bit got2;
        load_rows_at(11'h010, 11'h014, 11'h018, 11'h01C);
        out_if.out_ready = 1'b1;
        mon_clear();
        do_start(11'h010, 8'd4, 4'hF, 4'hF);
        got2 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (n_accepted >= 2) begin got2 = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!got2 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_two_beats got beats %0d busy %b exp 2 1", n_accepted, busy);
        end
        out_if.out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({out_if.out_valid, busy, done} !== 3'b000) begin
            n_errors++;
            $display("FAIL mid_reset got valid/busy/done %b exp 000", {out_if.out_valid, busy, done});
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_if.out_valid !== 1'b0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL mid_quiet got valid %b state %0d exp 0 0", out_if.out_valid, dbg_state);
        end
        out_if.out_ready = 1'b1;
        mon_clear();
        exp_q      = '{{1'b0, 2'd0, 32'h04030201}, {1'b0, 2'd1, 32'h08070605},
                       {1'b0, 2'd2, 32'h0C0B0A09}, {1'b1, 2'd3, 32'h100F0E0D}};
        exp_addr_q = '{11'h010, 11'h014, 11'h018, 11'h01C};
        do_start(11'h010, 8'd4, 4'hF, 4'hF);
        run_until_done(60, 1'b0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL mid_restart_timeout got no done exp done within 60 cycles"); end
        n_checks++;
        if (got_q != exp_q) begin
            n_errors++;
            $display("FAIL mid_restart_beats got %p exp %p", got_q, exp_q);
        end
        n_checks++;
        if (addr_log != exp_addr_q) begin
            n_errors++;
            $display("FAIL mid_restart_addrs got %p exp %p", addr_log, exp_addr_q);
        end
        pulse_clear_done();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        clear_done       = 1'b0;
        address_mat_c    = '0;
        address_stride_c = '0;
        rmask            = '0;
        cmask            = '0;
        out_if.out_ready = 1'b1;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 32'hA5A5A5A5;

        test_reset();
        test_full_drain();
        test_masked();
        test_backpressure();
        test_wrap();
        test_empty_mask();
        test_reset_mid_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/matmul_c_drain.md
Name: matmul_c_drain

Overview:
- Downstream stage of the 4x4 matmul block. After a multiply completes, it reads result matrix C out of the C BRAM's external port, one row per BRAM word.
- Each row is emitted on a valid/ready stream, e.g. toward a DMA or the next layer's loader.
- Handles the BRAM's 1-cycle registered read latency under backpressure with a 2-entry output buffer.
- Lane masking follows the matmul validity masks.

Parameters:
DWIDTH, 8, bits per matrix element
AWIDTH, 11, BRAM address width
MAT_MUL_SIZE, 4, rows in C and elements per BRAM word
ADDR_STRIDE_WIDTH, 8, width of row address stride

Ports:
clk  in  1  single clock; every register updates on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that begins a drain; honoured only in IDLE
clear_done  in  1  returns DONE to IDLE
address_mat_c  in  AWIDTH  BRAM address of row 0; sampled at start
address_stride_c  in  ADDR_STRIDE_WIDTH  address step between rows; sampled at start
validity_mask_a_rows  in  MAT_MUL_SIZE  bit i=1: row i of C is valid; sampled at start
validity_mask_b_cols  in  MAT_MUL_SIZE  bit j=1: lane j is valid; sampled at start
bram_addr_c_ext  out  AWIDTH  C BRAM external-port address
bram_rdata_c_ext  in  MAT_MUL_SIZE*DWIDTH  C BRAM read data, valid 1 cycle after the address
bram_wdata_c_ext  out  MAT_MUL_SIZE*DWIDTH  tied to 0
bram_we_c_ext  out  MAT_MUL_SIZE  tied to 0; this block never writes
out_data  out  MAT_MUL_SIZE*DWIDTH  one row; lane j = bits [j*DWIDTH +: DWIDTH]
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts; a beat transfers when out_valid && out_ready
out_row  out  LOG2(MAT_MUL_SIZE)  row index of the current beat
out_last  out  1  current beat is the last valid row
busy  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- Reset values:
  - State IDLE.
  - out_valid, out_last, busy, done = 0.
  - bram_addr_c_ext = 0; out_data = 0; out_row = 0.
  - Buffer emptied; in-flight read discarded.
  - Reset has priority over every other input, including during RUN (mid-drain): the partial drain is abandoned and no further beats are issued.
- FSM: IDLE -> RUN on start. RUN -> DONE once every valid row has been accepted downstream. DONE -> IDLE on clear_done.
  - start in RUN or DONE is ignored.
  - clear_done outside DONE is ignored.
- Start with validity_mask_a_rows == 0: IDLE -> RUN -> DONE on the next cycle. No BRAM reads, no beats.
- Issue order:
  - Rows i = 0..MAT_MUL_SIZE-1, ascending; rows with mask bit 0 are skipped (not read, not emitted).
  - Address of row i = address_mat_c + i*address_stride_c, computed modulo 2^AWIDTH (wraps; no error).
- Read issue rule: a read of the next valid row is issued in a cycle only if buffer_count + inflight < 2.
  - inflight is 1 if a read was issued the previous cycle.
  - A pop in the same cycle does not free a slot until the next cycle; conservative, so there is no overflow.
  - bram_addr_c_ext holds its last value when no read is issued.
- Read return: data returned 1 cycle after issue is pushed into the 2-entry FIFO, tagged with its row index and a last flag.
  - Lanes with validity_mask_b_cols bit 0 are forced to 0 before the push.
- Output:
  - out_valid = FIFO non-empty; out_data, out_row and out_last come from the FIFO head.
  - Payload holds stable while out_valid && !out_ready.
  - A push and pop in the same cycle are both honoured.
- Latency: with out_ready held at 1, the first beat's out_valid rises 2 cycles after start is sampled (issue cycle, then data cycle).
  - Sustained throughput is at least 1 row per 2 cycles; an implementation may reach 1 row per cycle.
- out_last is set on the highest-indexed valid row only.
- RUN -> DONE occurs in the cycle after the out_last beat transfers. busy falls and done rises together.

Test Plan:
- Masks 4'hF, base 0x010, stride 4, C rows preloaded 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, out_ready = 1 -> 4 beats in order with those values. out_row = 0..3; out_last only on row 3; done asserts; addresses 0x010, 0x014, 0x018, 0x01C.
- Row mask 4'b1010, col mask 4'b0011, same data -> exactly 2 beats: row1 = 0x00000605, row3 = 0x00000E0D (out_last). Rows 0 and 2 are never addressed.
- out_ready toggled randomly 50%, full masks -> beats arrive in order, no drop and no duplication. The payload is stable while stalled, and a scoreboard observes no more than 2 reads outstanding-or-buffered at any time.
- Base 0x7FE, stride 1, full masks -> addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Row mask 0 -> no reads and no beats; done rises 2 cycles after start. clear_done returns the block to IDLE, and a start pulse while in DONE has no effect.
- Reset asserted after 2 beats of a 4-row drain, with out_ready = 0 -> next cycle out_valid = 0, busy = 0, done = 0, and a fresh start drains all 4 rows correctly from row 0.
